multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
Execute-stage controller that owns the shared iterative multdiv unit. It latches operands when a mult or div instruction reaches X and emits the one-cycle start pulse. While the unit iterates it holds the pipeline stall, then delivers a one-cycle completion with the result or an rstatus exception value. It also handles flushes mid-operation by draining the unit and discarding its result, and it bounds runaway operations with a timeout.

Parameters:
WIDTH, 32, operand/result width
REG_BITS, 5, register index width
TIMEOUT, 64, max cycles in BUSY before forced exception
CNT_W, 7, timeout counter width (must hold TIMEOUT)
RSTATUS_REG, 30, destination register on exception
EXC_MULT, 4, rstatus value for mult overflow/timeout
EXC_DIV, 5, rstatus value for div-by-zero/timeout

Ports:
clock  in  1  master clock, all state on rising edge
reset  in  1  asynchronous, active-high
issue_valid  in  1  X stage holds a mult/div instruction
issue_is_div  in  1  1=div, 0=mult
issue_rd  in  REG_BITS  destination register
issue_a  in  WIDTH  bypassed operand A
issue_b  in  WIDTH  bypassed operand B
flush  in  1  X instruction is squashed this cycle
md_operandA  out  WIDTH  latched operand A to unit
md_operandB  out  WIDTH  latched operand B to unit
md_ctrl_mult  out  1  one-cycle start pulse, mult
md_ctrl_div  out  1  one-cycle start pulse, div
md_result  in  WIDTH  unit result
md_exception  in  1  unit exception, valid with md_resultRDY
md_resultRDY  in  1  unit done, one-cycle pulse
stall  out  1  freeze PC, F/D, D/X latches; insert nop into X/M
done  out  1  one-cycle completion
wb_rd  out  REG_BITS  destination, valid with done
wb_data  out  WIDTH  result or exception code, valid with done
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, counter=0, all latched registers 0. All outputs are 0 during and after reset until a new issue.
- States: IDLE, START, BUSY, DONE, DRAIN.
- IDLE: when issue_valid & ~flush, latch a, b, rd, and is_div, then go to START. stall is combinationally 1 in that same cycle.
- START: pulse md_ctrl_mult or md_ctrl_div (exactly one, for exactly one cycle). Clear counter. Go to BUSY. stall=1.
- BUSY: stall=1 and counter increments each cycle.
  - md_resultRDY: capture result/exception and go to DONE.
  - Else if counter==TIMEOUT-1: force exception and go to DONE.
- DONE: done=1 and stall=0 for one cycle, then go to IDLE.
  - No exception: wb_rd=latched rd and wb_data=captured result.
  - Exception: wb_rd=RSTATUS_REG and wb_data=EXC_DIV or EXC_MULT, zero-extended.
  - issue_valid is ignored in DONE. The next instruction reaches X one cycle later, when the state is IDLE.
- flush in START or BUSY: go to DRAIN with no done. A START-cycle flush still emits the pulse.
- flush in DONE: done is suppressed (forced 0) and the state goes to IDLE.
- DRAIN: wait for md_resultRDY, or for the counter to reach TIMEOUT-1, then go to IDLE and discard the result.
  - stall=0 unless issue_valid is 1, in which case stall=1 because the new op waits for the unit to free.
  - In DRAIN the counter continues to increment and is not cleared on entry.
- md_resultRDY outside BUSY/DRAIN is ignored.
- Simultaneous md_resultRDY and flush in BUSY: go to DRAIN-exit, i.e. directly to IDLE with no done.
- md_operandA/B are stable from START until the next IDLE acceptance.
- Total latency: issue cycle n → pulse n+1 → done at (cycle of md_resultRDY)+1.
- Reset asserted mid-operation returns the block to IDLE immediately.

Decomposition:
- Shared package: state encoding, EXC_MULT/EXC_DIV/RSTATUS_REG constants, and the mult/div opcode and ALUop constants used by the processor.
- One sub-module, md_timeout_counter: a CNT_W counter with clear, enable, and terminal-count output.
- FSM, latches, and output muxing stay in the top block.

Test Plan:
1. Mult 6×7, rd=3, unit ready after 32 cycles → one pulse of md_ctrl_mult; stall=1 for 34 cycles; done with wb_rd=3, wb_data=42; stall=0 on the done cycle.
2. Div 20÷0 with md_exception=1 → done with wb_rd=30, wb_data=5; md_ctrl_div pulses once only.
3. Flush in BUSY at cycle 5, then issue_valid → stall drops until issue_valid rises, no done is emitted; the new op starts only after the old md_resultRDY.
4. Unit never raises md_resultRDY (TIMEOUT=64) → done after 64 BUSY cycles with wb_rd=30, wb_data=4 for a mult.
5. Back-to-back mult then div → two distinct pulses, two done pulses, no overlap, operands latched correctly for each.
6. Reset asserted mid-BUSY → busy, stall, done, and both pulses go to 0 asynchronously; a following issue behaves like scenario 1.

Source files
------------

// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the execute-stage multdiv sequencer.
package multdiv_sequencer_pkg;

  localparam int unsigned MD_WIDTH       = 32;
  localparam int unsigned MD_REG_BITS    = 5;
  localparam int unsigned MD_TIMEOUT     = 64;
  localparam int unsigned MD_CNT_W       = 7;
  localparam int unsigned MD_RSTATUS_REG = 30;
  localparam int unsigned MD_EXC_MULT    = 4;
  localparam int unsigned MD_EXC_DIV     = 5;

  // Processor decode constants for the instructions this block serves
  localparam logic [4:0] OPCODE_ALU = 5'b00000;
  localparam logic [4:0] ALUOP_MUL  = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } md_state_e;

endpackage

// File: rtl/multdiv_sequencer_timeout_counter.sv
// Cycle counter bounding how long the multdiv unit may run.
module md_timeout_counter
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = MD_CNT_W,
  parameter int unsigned TIMEOUT = MD_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over enable so START always restarts the count from zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Execute-stage controller for the shared iterative multdiv unit.
module multdiv_sequencer
  import multdiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH       = MD_WIDTH,
  parameter int unsigned REG_BITS    = MD_REG_BITS,
  parameter int unsigned TIMEOUT     = MD_TIMEOUT,
  parameter int unsigned CNT_W       = MD_CNT_W,
  parameter int unsigned RSTATUS_REG = MD_RSTATUS_REG,
  parameter int unsigned EXC_MULT    = MD_EXC_MULT,
  parameter int unsigned EXC_DIV     = MD_EXC_DIV
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_is_div,
  input  logic [REG_BITS-1:0] issue_rd,
  input  logic [WIDTH-1:0]    issue_a,
  input  logic [WIDTH-1:0]    issue_b,
  input  logic                flush,
  output logic [WIDTH-1:0]    md_operandA,
  output logic [WIDTH-1:0]    md_operandB,
  output logic                md_ctrl_mult,
  output logic                md_ctrl_div,
  input  logic [WIDTH-1:0]    md_result,
  input  logic                md_exception,
  input  logic                md_resultRDY,
  output logic                stall,
  output logic                done,
  output logic [REG_BITS-1:0] wb_rd,
  output logic [WIDTH-1:0]    wb_data,
  output logic                busy
);

  md_state_e           state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [REG_BITS-1:0] rd_q;
  logic                is_div_q;
  logic                exc_q;
  logic [WIDTH-1:0]    result_q;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_tc;

  assign cnt_clr = (state_q == ST_START);
  assign cnt_en  = (state_q == ST_BUSY) || (state_q == ST_DRAIN);

  md_timeout_counter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .tc_o (cnt_tc)
  );

  // Sequencer state, operand latches and captured unit response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_valid && !flush) begin
            a_q      <= issue_a;
            b_q      <= issue_b;
            rd_q     <= issue_rd;
            is_div_q <= issue_is_div;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          state_q <= flush ? ST_DRAIN : ST_BUSY;
        end
        ST_BUSY: begin
          if (flush) begin
            // A unit that finishes (or times out) on the flush cycle is already free
            state_q <= (md_resultRDY || cnt_tc) ? ST_IDLE : ST_DRAIN;
          end else if (md_resultRDY) begin
            result_q <= md_result;
            exc_q    <= md_exception;
            state_q  <= ST_DONE;
          end else if (cnt_tc) begin
            exc_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (md_resultRDY || cnt_tc) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from state; stall also sees the live issue request
  always_comb begin
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    case (state_q)
      ST_IDLE:  stall = issue_valid && !flush;
      ST_START: begin
        stall        = 1'b1;
        md_ctrl_mult = !is_div_q;
        md_ctrl_div  = is_div_q;
      end
      ST_BUSY:  stall = 1'b1;
      ST_DONE:  done  = !flush;
      ST_DRAIN: stall = issue_valid;
      default:  stall = 1'b0;
    endcase
    if (done) begin
      if (exc_q) begin
        wb_rd   = REG_BITS'(RSTATUS_REG);
        wb_data = is_div_q ? WIDTH'(EXC_DIV) : WIDTH'(EXC_MULT);
      end else begin
        wb_rd   = rd_q;
        wb_data = result_q;
      end
    end
  end

  assign md_operandA = a_q;
  assign md_operandB = b_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed-vector bench for multdiv_sequencer with a hand-driven unit model.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_is_div;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic        flush;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        done;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  multdiv_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_is_div(issue_is_div),
    .issue_rd    (issue_rd),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .flush       (flush),
    .md_operandA (md_operandA),
    .md_operandB (md_operandB),
    .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div (md_ctrl_div),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .stall       (stall),
    .done        (done),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic set_issue(input logic v, input logic is_div, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
    issue_valid  = v;
    issue_is_div = is_div;
    issue_rd     = rd;
    issue_a      = a;
    issue_b      = b;
  endtask

  // Issue one op from IDLE, answer with md_resultRDY at cycle rdy_at after issue
  // (0 = never), and check the completion plus pulse and stall counts.
  task automatic run_op(input string tag, input logic is_div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input int rdy_at,
                        input logic exc, input logic [31:0] res, input int exp_done_at,
                        input logic [4:0] exp_rd, input logic [31:0] exp_data);
    int nm;
    int nd;
    int ns;
    int idx;
    bit seen;
    nm = 0; nd = 0; idx = 0; seen = 0;
    set_issue(1'b1, is_div, rd, a, b);
    #1;
    ns = int'(stall);
    while (!seen && idx < 300) begin
      cyc();
      idx++;
      set_issue(1'b0, 1'b0, 5'd31, 32'hdeadbeef, 32'hfeedface);
      md_resultRDY = (idx == rdy_at);
      md_exception = exc && (idx == rdy_at);
      md_result    = (idx == rdy_at) ? res : 32'h0bad0bad;
      #1;
      if (idx == 1) begin
        chk({tag, "_opA"}, md_operandA, a);
        chk({tag, "_opB"}, md_operandB, b);
      end
      nm += int'(md_ctrl_mult);
      nd += int'(md_ctrl_div);
      if (done) begin
        seen = 1;
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(exp_rd));
        chk({tag, "_wb_data"}, wb_data, exp_data);
        chk({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        chk({tag, "_done_cycle"}, 32'(idx), 32'(exp_done_at));
      end else begin
        ns += int'(stall);
      end
    end
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_mult_pulses"}, 32'(nm), is_div ? 32'd0 : 32'd1);
    chk({tag, "_div_pulses"}, 32'(nd), is_div ? 32'd1 : 32'd0);
    chk({tag, "_stall_cycles"}, 32'(ns), 32'(exp_done_at));
    cyc();
    #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    md_result = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    set_issue(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    cyc();
    cyc();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pulses", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
    chk("rst_opA", md_operandA, 32'd0);
    reset = 1'b0;
    cyc();
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wb", wb_data, 32'd0);

    // Mult 6x7, unit ready in the 32nd BUSY cycle
    run_op("mul6x7", 1'b0, 5'd3, 32'd6, 32'd7, 33, 1'b0, 32'd42, 34, 5'd3, 32'd42);

    // Div 20/0 reports exception -> rstatus=5
    run_op("div_by0", 1'b1, 5'd12, 32'd20, 32'd0, 5, 1'b1, 32'd0, 6, 5'd30, 32'd5);

    // Mult overflow reported by the unit -> rstatus=4
    run_op("mul_ovf", 1'b0, 5'd9, 32'h40000000, 32'd4, 3, 1'b1, 32'd0, 4, 5'd30, 32'd4);

    // Unit never answers: 64 BUSY cycles then forced mult exception
    run_op("mul_tmo", 1'b0, 5'd7, 32'd3, 32'd5, 0, 1'b0, 32'd0, 66, 5'd30, 32'd4);

    // Back-to-back mult then div
    run_op("b2b_mul", 1'b0, 5'd7, 32'd100, 32'd3, 4, 1'b0, 32'd300, 5, 5'd7, 32'd300);
    run_op("b2b_div", 1'b1, 5'd9, 32'd100, 32'd7, 10, 1'b0, 32'd14, 11, 5'd9, 32'd14);

    // Flush in BUSY at cycle 5, new div waits for the old unit result
    set_issue(1'b1, 1'b0, 5'd5, 32'd1, 32'd2);
    #1;
    chk("fl_issue_stall", 32'(stall), 32'd1);
    cyc();
    set_issue(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    #1;
    chk("fl_start_pulse", 32'(md_ctrl_mult), 32'd1);
    for (int i = 2; i <= 4; i++) cyc();
    cyc();
    flush = 1'b1;
    #1;
    chk("fl_busy_stall", 32'(stall), 32'd1);
    cyc();
    flush = 1'b0;
    #1;
    chk("fl_drain_busy", 32'(busy), 32'd1);
    chk("fl_drain_stall0", 32'(stall), 32'd0);
    chk("fl_drain_done0", 32'(done), 32'd0);
    cyc();
    cyc();
    set_issue(1'b1, 1'b1, 5'd6, 32'd50, 32'd5);
    #1;
    chk("fl_drain_stall1", 32'(stall), 32'd1);
    cyc();
    #1;
    chk("fl_drain_nopulse", 32'(md_ctrl_div), 32'd0);
    cyc();
    md_resultRDY = 1'b1;
    md_result = 32'd999;
    #1;
    chk("fl_rdy_done0", 32'(done), 32'd0);
    chk("fl_rdy_stall", 32'(stall), 32'd1);
    cyc();
    md_resultRDY = 1'b0;
    #1;
    chk("fl_idle_after_drain", 32'(busy), 32'd0);
    chk("fl_idle_stall", 32'(stall), 32'd1);
    chk("fl_idle_done0", 32'(done), 32'd0);
    run_op("fl_next_div", 1'b1, 5'd6, 32'd50, 32'd5, 4, 1'b0, 32'd10, 5, 5'd6, 32'd10);

    // Simultaneous md_resultRDY and flush in BUSY -> straight to IDLE
    set_issue(1'b1, 1'b0, 5'd8, 32'd2, 32'd2);
    cyc();
    set_issue(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    cyc();
    md_resultRDY = 1'b1;
    md_result = 32'd4;
    flush = 1'b1;
    cyc();
    md_resultRDY = 1'b0;
    flush = 1'b0;
    #1;
    chk("rdyfl_idle", 32'(busy), 32'd0);
    chk("rdyfl_done0", 32'(done), 32'd0);

    // Flush in START still pulses, then drains
    set_issue(1'b1, 1'b0, 5'd8, 32'd2, 32'd3);
    cyc();
    set_issue(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    flush = 1'b1;
    #1;
    chk("flstart_pulse", 32'(md_ctrl_mult), 32'd1);
    cyc();
    flush = 1'b0;
    #1;
    chk("flstart_drain", 32'(busy), 32'd1);
    chk("flstart_stall0", 32'(stall), 32'd0);
    cyc();
    md_resultRDY = 1'b1;
    cyc();
    md_resultRDY = 1'b0;
    #1;
    chk("flstart_idle", 32'(busy), 32'd0);
    chk("flstart_done0", 32'(done), 32'd0);

    // Flush on the DONE cycle suppresses done
    set_issue(1'b1, 1'b1, 5'd4, 32'd9, 32'd3);
    cyc();
    set_issue(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    cyc();
    md_resultRDY = 1'b1;
    md_result = 32'd3;
    cyc();
    md_resultRDY = 1'b0;
    flush = 1'b1;
    #1;
    chk("fldone_done0", 32'(done), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fldone_idle", 32'(busy), 32'd0);

    // md_resultRDY while IDLE is ignored
    md_resultRDY = 1'b1;
    cyc();
    md_resultRDY = 1'b0;
    #1;
    chk("idle_rdy_busy", 32'(busy), 32'd0);
    chk("idle_rdy_done", 32'(done), 32'd0);

    // Asynchronous reset in the middle of BUSY
    set_issue(1'b1, 1'b0, 5'd2, 32'd11, 32'd12);
    cyc();
    set_issue(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    cyc();
    cyc();
    #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pulses", 32'({md_ctrl_mult, md_ctrl_div}), 32'd0);
    chk("midrst_opA", md_operandA, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    run_op("post_rst_mul", 1'b0, 5'd3, 32'd6, 32'd7, 33, 1'b0, 32'd42, 34, 5'd3, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
